// File: rtl/sfm_tcdm_responder_if.sv
// TCDM port bundle: MP parallel 32-bit word ports. The master modport is
// the initiator side (accelerator or testbench driver) and the slave
// modport is the responder/memory side.
`timescale 1ns/1ps

interface sfm_tcdm_responder_if #(
  parameter int MP = 4
);

  logic [MP-1:0]       req;
  logic [MP-1:0]       gnt;
  logic [MP-1:0][31:0] add;
  logic [MP-1:0]       wen;     // 1 = read, 0 = write
  logic [MP-1:0][3:0]  be;
  logic [MP-1:0][31:0] data;
  logic [MP-1:0][31:0] r_data;
  logic [MP-1:0]       r_valid;

  modport master (
    output req, add, wen, be, data,
    input  gnt, r_data, r_valid
  );

  modport slave (
    input  req, add, wen, be, data,
    output gnt, r_data, r_valid
  );

endinterface

// File: rtl/sfm_tcdm_responder.sv
// sfm_tcdm_responder: multi-port TCDM slave and word memory model.
// Grants every request except on the periodic throttle cycle, performs
// byte-enabled writes and old-data reads, and returns one response per
// granted access after a fixed LATENCY-deep pipeline.
// Optional build macro SFM_TCDM_RESP_ERR_EN: out-of-range accesses are
// flagged (sticky err_o), writes dropped, reads return 32'hDEAD_BEEF.
// Without it addresses wrap modulo NWORDS and err_o is tied low.
`timescale 1ns/1ps

module sfm_tcdm_responder #(
  parameter int          MP          = 4,
  parameter int          NWORDS      = 1024,          // power of two
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          LATENCY     = 1,             // 1..4
  parameter int          STALL_EVERY = 0              // 0 = no throttling
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  sfm_tcdm_responder_if.slave  tcdm,
  output logic                 err_o
);

  localparam int          AW       = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int          CW       = (STALL_EVERY > 1) ? $clog2(STALL_EVERY) : 1;
  localparam logic [CW-1:0] CNT_LAST = (STALL_EVERY > 0) ? CW'(STALL_EVERY - 1) : '0;
  localparam logic [31:0] OOR_DATA = 32'hDEAD_BEEF;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } rsp_t;

  logic [CW-1:0]         stall_cnt;
  logic                  stall;
  logic [MP-1:0]         fire;
  logic [MP-1:0]         rd_fire;
  logic [MP-1:0]         wr_fire;
  logic [MP-1:0]         oor;
  logic [MP-1:0][31:0]   offset;
  logic [MP-1:0][AW-1:0] idx;
  logic [MP-1:0][31:0]   rd_word;

  logic [31:0] mem [NWORDS];
  rsp_t        pipe [MP][LATENCY];

  // Throttle counter: free-running 0..STALL_EVERY-1, held at 0 when disabled
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt <= '0;
    end else if (STALL_EVERY <= 1 || stall) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + CW'(1);
    end
  end

  assign stall = (STALL_EVERY != 0) && (stall_cnt == CNT_LAST);

  // All ports stall together; nothing is granted while reset is held
  assign tcdm.gnt = tcdm.req & {MP{~stall & rst_ni}};

  // Address decode, range check and old-data read of the current word
  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    offset  = '0;
    idx     = '0;
    oor     = '0;
    rd_word = '0;
    for (int i = 0; i < MP; i++) begin
      offset[i] = tcdm.add[i] - BASE_ADDR;
      idx[i]    = offset[i][AW+1:2];
`ifdef SFM_TCDM_RESP_ERR_EN
      // Below the base (borrow) or past the last word is out of range
      oor[i]    = (tcdm.add[i] < BASE_ADDR) || ((offset[i] >> (AW + 2)) != '0);
`endif
      rd_word[i] = oor[i] ? OOR_DATA : mem[idx[i]];
    end
  end

  assign fire    = tcdm.gnt;
  assign rd_fire = fire & tcdm.wen;
  assign wr_fire = fire & ~tcdm.wen & ~oor;

  // Byte-enabled writes; a later (higher-index) port overrides lower ones
  // NOTE: memory has no reset branch -- contents survive rst_ni, and a
  // reset on a large array would prevent RAM inference. Non-blocking
  // updates mean same-edge reads above still see the old word, and among
  // several NBAs to one byte the last one in loop order takes effect.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < MP; i++) begin
      if (wr_fire[i]) begin
        for (int b = 0; b < 4; b++) begin
          if (tcdm.be[i][b]) begin
            mem[idx[i]][8*b +: 8] <= tcdm.data[i][8*b +: 8];
          end
        end
      end
    end
  end

  // Per-port response shift register, flushed by reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MP; i++) begin
        for (int s = 0; s < LATENCY; s++) begin
          pipe[i][s] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < MP; i++) begin
        pipe[i][0].valid <= fire[i];
        pipe[i][0].data  <= rd_fire[i] ? rd_word[i] : 32'h0;
        for (int s = 1; s < LATENCY; s++) begin
          pipe[i][s] <= pipe[i][s-1];
        end
      end
    end
  end

  // Responses come straight from the last pipeline stage
  always_comb begin
    tcdm.r_valid = '0;
    tcdm.r_data  = '0;
    for (int i = 0; i < MP; i++) begin
      tcdm.r_valid[i] = pipe[i][LATENCY-1].valid;
      tcdm.r_data[i]  = pipe[i][LATENCY-1].data;
    end
  end

`ifdef SFM_TCDM_RESP_ERR_EN
  logic err_q;

  // Sticky range-error flag, cleared only by reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (|(fire & oor)) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  // Byte-offset bits and high offset bits are intentionally ignored
  logic unused_offset;
  assign unused_offset = ^offset;

endmodule

// File: tb/tb_sfm_tcdm_responder.sv
// Self-checking bench for sfm_tcdm_responder. Two instances run side by
// side: A (LATENCY=1, no throttling) and B (LATENCY=3, STALL_EVERY=4).
// A transaction-level model (byte-wise memory arrays, per-port pending
// and response queues, cycle arithmetic for the throttle) predicts every
// grant, response and error flag.
`timescale 1ns/1ps

module tb_sfm_tcdm_responder;

  localparam int          MP   = 4;
  localparam int          NW   = 1024;
  localparam int          NDUT = 2;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  sfm_tcdm_responder_if #(.MP(MP)) if_a ();
  sfm_tcdm_responder_if #(.MP(MP)) if_b ();
  logic err_a, err_b;

  sfm_tcdm_responder #(
    .MP(MP), .NWORDS(NW), .BASE_ADDR(BASE), .LATENCY(1), .STALL_EVERY(0)
  ) u_dut_a (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .tcdm  (if_a),
    .err_o (err_a)
  );

  sfm_tcdm_responder #(
    .MP(MP), .NWORDS(NW), .BASE_ADDR(BASE), .LATENCY(3), .STALL_EVERY(4)
  ) u_dut_b (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .tcdm  (if_b),
    .err_o (err_b)
  );

  // Stimulus and observation arrays, index 0 = A, 1 = B
  logic [MP-1:0]       req_d  [NDUT];
  logic [MP-1:0]       wen_d  [NDUT];
  logic [MP-1:0][3:0]  be_d   [NDUT];
  logic [MP-1:0][31:0] add_d  [NDUT];
  logic [MP-1:0][31:0] data_d [NDUT];
  logic [MP-1:0]       gnt_o  [NDUT];
  logic [MP-1:0]       rv_o   [NDUT];
  logic [MP-1:0][31:0] rd_o   [NDUT];
  logic                err_v  [NDUT];

  assign if_a.req = req_d[0];  assign if_b.req = req_d[1];
  assign if_a.wen = wen_d[0];  assign if_b.wen = wen_d[1];
  assign if_a.be  = be_d[0];   assign if_b.be  = be_d[1];
  assign if_a.add = add_d[0];  assign if_b.add = add_d[1];
  assign if_a.data = data_d[0]; assign if_b.data = data_d[1];
  assign gnt_o[0] = if_a.gnt;  assign gnt_o[1] = if_b.gnt;
  assign rv_o[0]  = if_a.r_valid; assign rv_o[1] = if_b.r_valid;
  assign rd_o[0]  = if_a.r_data;  assign rd_o[1] = if_b.r_data;
  assign err_v[0] = err_a;     assign err_v[1] = err_b;

  typedef struct {
    bit          wen;
    logic [3:0]  be;
    logic [31:0] add;
    logic [31:0] data;
    bit          has_exp;
    logic [31:0] exp;
  } txn_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  txn_t        pend  [NDUT][MP][$];
  rsp_t        rsp_q [NDUT][MP][$];
  logic [31:0] mem_m [NDUT][NW];
  bit          exp_err [NDUT];
  int          cyc;
  int          n_checks;
  int          n_fail;
  int          rv_cnt  [NDUT][MP];
  int          gnt_cnt [NDUT][MP];

  function automatic int lat_of(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int se_of(int d);
    return (d == 0) ? 0 : 4;
  endfunction

  function automatic int word_of(logic [31:0] add);
    logic [31:0] off;
    off = add - BASE;
    return int'((off / 4) % NW);
  endfunction

  function automatic bit out_of_range(logic [31:0] add);
`ifdef SFM_TCDM_RESP_ERR_EN
    return (add < BASE) || ((add - BASE) >= 32'(NW * 4));
`else
    return (add == 32'h0) && (add != 32'h0);
`endif
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push(int d, int p, bit wen, logic [3:0] be, logic [31:0] add,
                      logic [31:0] data, bit has_exp = 1'b0, logic [31:0] exp = '0);
    txn_t t;
    t.wen = wen; t.be = be; t.add = add; t.data = data;
    t.has_exp = has_exp; t.exp = exp;
    pend[d][p].push_back(t);
  endtask

  task automatic push_both(int p, bit wen, logic [3:0] be, logic [31:0] add,
                           logic [31:0] data, bit has_exp = 1'b0, logic [31:0] exp = '0);
    for (int d = 0; d < NDUT; d++) push(d, p, wen, be, add, data, has_exp, exp);
  endtask

  function automatic bit busy();
    for (int d = 0; d < NDUT; d++)
      for (int p = 0; p < MP; p++)
        if (pend[d][p].size() != 0 || rsp_q[d][p].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // One clock cycle: drive queue heads, check grants, advance the model,
  // then check responses and the error flag after the edge.
  task automatic step();
    bit   g [NDUT][MP];
    txn_t t [NDUT][MP];
    bit   err_set [NDUT];
    for (int d = 0; d < NDUT; d++) begin
      for (int p = 0; p < MP; p++) begin
        if (pend[d][p].size() != 0) begin
          req_d[d][p]  = 1'b1;
          wen_d[d][p]  = pend[d][p][0].wen;
          be_d[d][p]   = pend[d][p][0].be;
          add_d[d][p]  = pend[d][p][0].add;
          data_d[d][p] = pend[d][p][0].data;
        end else begin
          req_d[d][p]  = 1'b0;
          wen_d[d][p]  = 1'($urandom);
          be_d[d][p]   = 4'($urandom);
          add_d[d][p]  = BASE + 32'($urandom_range(0, 15) * 4);
          data_d[d][p] = $urandom;
        end
      end
    end
    #1;
    for (int d = 0; d < NDUT; d++) begin
      bit stall;
      stall = (se_of(d) != 0) && ((cyc % se_of(d)) == se_of(d) - 1);
      // Reads see the memory as it was before any write of this cycle
      for (int p = 0; p < MP; p++) begin
        logic [31:0] rdata;
        g[d][p] = (pend[d][p].size() != 0) && !stall;
        check($sformatf("gnt d%0d p%0d c%0d", d, p, cyc), 32'(gnt_o[d][p]), 32'(g[d][p]));
        if (gnt_o[d][p]) gnt_cnt[d][p]++;
        if (g[d][p]) begin
          t[d][p] = pend[d][p].pop_front();
          if (out_of_range(t[d][p].add)) err_set[d] = 1'b1;
          if (!t[d][p].wen) rdata = 32'h0;
          else if (t[d][p].has_exp) rdata = t[d][p].exp;
          else if (out_of_range(t[d][p].add)) rdata = 32'hDEAD_BEEF;
          else rdata = mem_m[d][word_of(t[d][p].add)];
          rsp_q[d][p].push_back('{due: cyc + lat_of(d), data: rdata});
        end
      end
      // Ascending port order lets the highest port win each byte
      for (int p = 0; p < MP; p++) begin
        if (g[d][p] && !t[d][p].wen && !out_of_range(t[d][p].add)) begin
          for (int b = 0; b < 4; b++)
            if (t[d][p].be[b])
              mem_m[d][word_of(t[d][p].add)][8*b +: 8] = t[d][p].data[8*b +: 8];
        end
      end
    end
    @(posedge clk_i);
    cyc++;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      if (err_set[d]) exp_err[d] = 1'b1;
      check($sformatf("err d%0d c%0d", d, cyc), 32'(err_v[d]), 32'(exp_err[d]));
      for (int p = 0; p < MP; p++) begin
        bit exp_v;
        exp_v = (rsp_q[d][p].size() != 0) && (rsp_q[d][p][0].due == cyc);
        check($sformatf("r_valid d%0d p%0d c%0d", d, p, cyc), 32'(rv_o[d][p]), 32'(exp_v));
        if (rv_o[d][p]) rv_cnt[d][p]++;
        if (exp_v) begin
          rsp_t r;
          r = rsp_q[d][p].pop_front();
          check($sformatf("r_data d%0d p%0d c%0d", d, p, cyc), rd_o[d][p], r.data);
        end
      end
    end
  endtask

  task automatic drain(int budget);
    int n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    check("drain within budget", 32'(busy()), 32'h0);
  endtask

  // Assert reset with requests raised, check outputs, release on a cycle boundary
  task automatic do_reset();
    rst_ni = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      req_d[d] = '1;
      for (int p = 0; p < MP; p++) add_d[d][p] = BASE + 32'($urandom_range(0, 15) * 4);
    end
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("reset err d%0d", d), 32'(err_v[d]), 32'h0);
      for (int p = 0; p < MP; p++) begin
        check($sformatf("reset gnt d%0d p%0d", d, p), 32'(gnt_o[d][p]), 32'h0);
        check($sformatf("reset r_valid d%0d p%0d", d, p), 32'(rv_o[d][p]), 32'h0);
        check($sformatf("reset r_data d%0d p%0d", d, p), rd_o[d][p], 32'h0);
        pend[d][p].delete();
        rsp_q[d][p].delete();
      end
      exp_err[d] = 1'b0;
      req_d[d]   = '0;
    end
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    cyc    = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
`ifdef SFM_TCDM_RESP_ERR_EN
    if ($urandom_range(0, 15) == 0) a = BASE - 32'($urandom_range(1, 8) * 4);
    else if ($urandom_range(0, 15) == 0) a = BASE + 32'(NW * 4) + 32'($urandom_range(0, 8) * 4);
`else
    if ($urandom_range(0, 3) == 0) a = a + 32'(NW * 4 * $urandom_range(1, 3));
    else if ($urandom_range(0, 7) == 0) a = a - 32'(NW * 4);
`endif
    return a;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    rst_ni   = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      req_d[d] = '0; wen_d[d] = '0; be_d[d] = '0; add_d[d] = '0; data_d[d] = '0;
    end
    #3;
    do_reset();

    // Known contents for the random region and for a few directed words
    for (int w = 0; w < 16; w++) push_both(w % MP, 1'b0, 4'hF, BASE + 32'(w * 4), $urandom);
    push_both(0, 1'b0, 4'hF, BASE + 32'(100 * 4), 32'h600D_F00D);
    push_both(1, 1'b0, 4'hF, BASE + 32'(101 * 4), 32'h0BAD_CAFE);
    drain(100);

    // Full-word write then readback
    push_both(0, 1'b0, 4'hF, 32'h1000_0010, 32'hCAFE_BABE);
    push_both(0, 1'b1, 4'h0, 32'h1000_0010, 32'h0, 1'b1, 32'hCAFE_BABE);
    drain(50);

    // Partial byte enables, back-to-back on one port
    push_both(0, 1'b0, 4'hF,    BASE, 32'h1122_3344);
    push_both(0, 1'b0, 4'b0101, BASE, 32'hAABB_CCDD);
    push_both(0, 1'b1, 4'h0,    BASE, 32'h0, 1'b1, 32'h11BB_33DD);
    // be = 0 write is a no-op
    push_both(1, 1'b0, 4'h0,    BASE + 32'(101 * 4), 32'hFFFF_FFFF);
    push_both(1, 1'b1, 4'h0,    BASE + 32'(101 * 4), 32'h0, 1'b1, 32'h0BAD_CAFE);
    drain(50);

    // Same-cycle conflict on word 5 plus a same-cycle read of the old value
    push_both(0, 1'b0, 4'hF, BASE + 32'h14, 32'h1234_5678);
    drain(50);
    push_both(0, 1'b0, 4'hF, BASE + 32'h14, 32'h0000_0000);
    push_both(3, 1'b0, 4'hF, BASE + 32'h14, 32'hFFFF_FFFF);
    push_both(1, 1'b1, 4'h0, BASE + 32'h14, 32'h0, 1'b1, 32'h1234_5678);
    drain(50);
    push_both(2, 1'b1, 4'h0, BASE + 32'h14, 32'h0, 1'b1, 32'hFFFF_FFFF);
    drain(50);

`ifdef SFM_TCDM_RESP_ERR_EN
    // Out-of-range read and dropped out-of-range write
    push_both(0, 1'b0, 4'hF, 32'h1000_0FFC, 32'h5A5A_5A5A);
    drain(50);
    push_both(0, 1'b1, 4'h0, 32'h1000_1000, 32'h0, 1'b1, 32'hDEAD_BEEF);
    drain(50);
    for (int d = 0; d < NDUT; d++) check($sformatf("err sticky d%0d", d), 32'(err_v[d]), 32'h1);
    push_both(0, 1'b0, 4'hF, 32'h0FFF_FFFC, 32'h0000_0000);
    push_both(0, 1'b1, 4'h0, 32'h1000_0FFC, 32'h0, 1'b1, 32'h5A5A_5A5A);
    drain(50);
    do_reset();
`else
    // Aliased address wraps onto the same word
    push_both(2, 1'b1, 4'h0, BASE + 32'(NW * 4 + 100 * 4) + 32'h3, 32'h0, 1'b1, 32'h600D_F00D);
    drain(50);
`endif

    // Randomized traffic on both instances
    for (int n = 0; n < 400; n++) begin
      for (int d = 0; d < NDUT; d++)
        for (int p = 0; p < MP; p++)
          if (pend[d][p].size() == 0 && $urandom_range(0, 9) < 7)
            push(d, p, 1'($urandom), 4'($urandom), rand_addr(), $urandom);
      step();
    end
    drain(100);

    // Throttling on B: requests held on every port for 12 cycles after reset
    do_reset();
    for (int p = 0; p < MP; p++) begin
      rv_cnt[1][p]  = 0;
      gnt_cnt[1][p] = 0;
      for (int k = 0; k < 10; k++) push(1, p, 1'b1, 4'h0, BASE + 32'(100 * 4), 32'h0, 1'b1, 32'h600D_F00D);
    end
    for (int n = 0; n < 12; n++) step();
    for (int p = 0; p < MP; p++)
      check($sformatf("grants in 12 cycles p%0d", p), 32'(gnt_cnt[1][p]), 32'd9);
    drain(50);
    for (int p = 0; p < MP; p++)
      check($sformatf("responses p%0d", p), 32'(rv_cnt[1][p]), 32'd10);

    // Reset with two reads in flight on B: responses lost, memory retained
    do_reset();
    push(1, 0, 1'b1, 4'h0, BASE + 32'(100 * 4), 32'h0);
    push(1, 0, 1'b1, 4'h0, BASE + 32'(101 * 4), 32'h0);
    step();
    step();
    do_reset();
    for (int n = 0; n < 6; n++) step();
    push(1, 0, 1'b1, 4'h0, BASE + 32'(100 * 4), 32'h0, 1'b1, 32'h600D_F00D);
    push(1, 1, 1'b1, 4'h0, BASE + 32'(101 * 4), 32'h0, 1'b1, 32'h0BAD_CAFE);
    push(0, 0, 1'b1, 4'h0, BASE + 32'(100 * 4), 32'h0, 1'b1, 32'h600D_F00D);
    drain(50);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
